rdmx_cfg_loader: RTL

- AXI4-Lite master that programs the rdmx shim configuration register bank: RFD/RMD address and size, and RFC address.
- On a start pulse it latches five 64-bit config values and writes them as ten 32-bit registers, high word before low word.
- Optionally reads all ten registers back and compares each against the value written.
- Sits between the board-bring-up sequencer and the shim-control slave, so configuration needs no host software.

---
 rtl/rdmx_cfg_pkg.sv | 41 ++++
 rtl/axil_single_xact.sv | 124 ++++++++++++
 rtl/rdmx_cfg_loader.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/rdmx_cfg_pkg.sv
// rtl/rdmx_cfg_pkg.sv - shared register map, AXI response codes, error codes and state encodings for the rdmx config loader
package rdmx_cfg_pkg;

    localparam int NUM_CFG_REGS = 10;

    localparam logic [3:0] REG_RFD_ADDR_H = 4'd0;
    localparam logic [3:0] REG_RFD_ADDR_L = 4'd1;
    localparam logic [3:0] REG_RFD_SIZE_H = 4'd2;
    localparam logic [3:0] REG_RFD_SIZE_L = 4'd3;
    localparam logic [3:0] REG_RMD_ADDR_H = 4'd4;
    localparam logic [3:0] REG_RMD_ADDR_L = 4'd5;
    localparam logic [3:0] REG_RMD_SIZE_H = 4'd6;
    localparam logic [3:0] REG_RMD_SIZE_L = 4'd7;
    localparam logic [3:0] REG_RFC_ADDR_H = 4'd8;
    localparam logic [3:0] REG_RFC_ADDR_L = 4'd9;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BRESP    = 2'd1;
    localparam logic [1:0] ERR_RRESP    = 2'd2;
    localparam logic [1:0] ERR_MISMATCH = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_FINISH
    } ld_state_t;

    typedef enum logic [1:0] {
        XS_IDLE,
        XS_ADDR,
        XS_RESP
    } xact_state_t;

endpackage

// File: rtl/axil_single_xact.sv
// rtl/axil_single_xact.sv - single-outstanding AXI4-Lite transaction engine (one write or one read at a time)
module axil_single_xact
    import rdmx_cfg_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        go,
    input  logic        rw,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        req_done,
    output logic        ack,
    output logic [1:0]  resp,
    output logic [31:0] rdata,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [2:0]  m_axi_awprot,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    output logic [2:0]  m_axi_arprot,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    xact_state_t x_state_q, x_state_d;
    logic        rw_q, rw_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        aw_pend, w_pend, ar_pend, is_rd;

    // VALIDs are combinational from go in XS_IDLE so a request leaves on the
    // cycle the caller asks for it; payload comes straight from the caller,
    // which holds addr/wdata steady for the whole request.
    always_comb begin
        x_state_d    = x_state_q;
        rw_d         = rw_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        req_done     = 1'b0;
        ack          = 1'b0;
        aw_pend      = 1'b0;
        w_pend       = 1'b0;
        ar_pend      = 1'b0;
        m_axi_bready = 1'b0;
        m_axi_rready = 1'b0;
        is_rd        = rw_q;
        case (x_state_q)
            XS_IDLE: begin
                is_rd = rw;
                if (go) begin
                    rw_d    = rw;
                    aw_pend = ~rw;
                    w_pend  = ~rw;
                    ar_pend = rw;
                end
            end
            XS_ADDR: begin
                aw_pend = ~rw_q & ~aw_done_q;
                w_pend  = ~rw_q & ~w_done_q;
                ar_pend = rw_q;
            end
            XS_RESP: begin
                m_axi_bready = ~rw_q;
                m_axi_rready = rw_q;
                if ((m_axi_bvalid & ~rw_q) | (m_axi_rvalid & rw_q)) begin
                    ack       = 1'b1;
                    x_state_d = XS_IDLE;
                end
            end
            default: x_state_d = XS_IDLE;
        endcase

        if (aw_pend | w_pend | ar_pend) begin
            aw_done_d = aw_done_q | (aw_pend & m_axi_awready);
            w_done_d  = w_done_q | (w_pend & m_axi_wready);
            if (is_rd ? m_axi_arready : (aw_done_d & w_done_d)) begin
                req_done  = 1'b1;
                x_state_d = XS_RESP;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end else begin
                x_state_d = XS_ADDR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_state_q <= XS_IDLE;
            rw_q      <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            x_state_q <= x_state_d;
            rw_q      <= rw_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign resp          = rw_q ? m_axi_rresp : m_axi_bresp;
    assign rdata         = m_axi_rdata;
    assign m_axi_awaddr  = addr;
    assign m_axi_awvalid = aw_pend;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wdata   = wdata;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = w_pend;
    assign m_axi_araddr  = addr;
    assign m_axi_arvalid = ar_pend;
    assign m_axi_arprot  = 3'b000;

endmodule

// File: rtl/rdmx_cfg_loader.sv
// rtl/rdmx_cfg_loader.sv - AXI4-Lite master writing (and optionally verifying) the ten rdmx shim config registers
module rdmx_cfg_loader
    import rdmx_cfg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          VERIFY    = 1,
    parameter int          NUM_REGS  = 10
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [63:0] cfg_rfd_addr,
    input  logic [63:0] cfg_rfd_size,
    input  logic [63:0] cfg_rmd_addr,
    input  logic [63:0] cfg_rmd_size,
    input  logic [63:0] cfg_rfc_addr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [3:0]  err_index,
    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [2:0]  M_AXI_AWPROT,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    output logic [2:0]  M_AXI_ARPROT,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    if (NUM_REGS != NUM_CFG_REGS) begin : g_bad_num_regs
        $error("rdmx_cfg_loader: NUM_REGS must be 10");
    end

    ld_state_t                        state_q, state_d;
    logic [3:0]                       idx_q, idx_d;
    logic [NUM_CFG_REGS-1:0][31:0]    words_q, words_d;
    logic [1:0]                       err_code_q, err_code_d;
    logic [3:0]                       err_index_q, err_index_d;
    logic                             error_q, error_d;

    logic        go, rw, req_done, ack;
    logic [1:0]  resp;
    logic [31:0] rdata, cur_addr;

    assign cur_addr = BASE_ADDR + {26'd0, idx_q, 2'b00};

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        words_d     = words_q;
        err_code_d  = err_code_q;
        err_index_d = err_index_q;
        error_d     = error_q;
        go          = 1'b0;
        rw          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    words_d[REG_RFD_ADDR_H] = cfg_rfd_addr[63:32];
                    words_d[REG_RFD_ADDR_L] = cfg_rfd_addr[31:0];
                    words_d[REG_RFD_SIZE_H] = cfg_rfd_size[63:32];
                    words_d[REG_RFD_SIZE_L] = cfg_rfd_size[31:0];
                    words_d[REG_RMD_ADDR_H] = cfg_rmd_addr[63:32];
                    words_d[REG_RMD_ADDR_L] = cfg_rmd_addr[31:0];
                    words_d[REG_RMD_SIZE_H] = cfg_rmd_size[63:32];
                    words_d[REG_RMD_SIZE_L] = cfg_rmd_size[31:0];
                    words_d[REG_RFC_ADDR_H] = cfg_rfc_addr[63:32];
                    words_d[REG_RFC_ADDR_L] = cfg_rfc_addr[31:0];
                    err_code_d  = ERR_NONE;
                    err_index_d = 4'd0;
                    error_d     = 1'b0;
                    idx_d       = 4'd0;
                    state_d     = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                go = 1'b1;
                if (req_done) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (ack) begin
                    if (resp != AXI_RESP_OKAY) begin
                        err_code_d  = ERR_BRESP;
                        err_index_d = idx_q;
                        state_d     = ST_FINISH;
                    end else if (idx_q == REG_RFC_ADDR_L) begin
                        idx_d   = 4'd0;
                        state_d = (VERIFY != 0) ? ST_RD_REQ : ST_FINISH;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_WR_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                go = 1'b1;
                rw = 1'b1;
                if (req_done) state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (ack) begin
                    if (resp != AXI_RESP_OKAY) begin
                        err_code_d  = ERR_RRESP;
                        err_index_d = idx_q;
                        state_d     = ST_FINISH;
                    end else if (rdata != words_q[idx_q]) begin
                        err_code_d  = ERR_MISMATCH;
                        err_index_d = idx_q;
                        state_d     = ST_FINISH;
                    end else if (idx_q == REG_RFC_ADDR_L) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // error becomes visible together with the done pulse
        if (state_d == ST_FINISH && state_q != ST_FINISH) begin
            error_d = (err_code_d != ERR_NONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            idx_q       <= 4'd0;
            words_q     <= '0;
            err_code_q  <= ERR_NONE;
            err_index_q <= 4'd0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            words_q     <= words_d;
            err_code_q  <= err_code_d;
            err_index_q <= err_index_d;
            error_q     <= error_d;
        end
    end

    assign busy      = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign done      = (state_q == ST_FINISH);
    assign error     = error_q;
    assign err_code  = err_code_q;
    assign err_index = err_index_q;

    axil_single_xact u_xact (
        .clk           (clk),
        .resetn        (resetn),
        .go            (go),
        .rw            (rw),
        .addr          (cur_addr),
        .wdata         (words_q[idx_q]),
        .req_done      (req_done),
        .ack           (ack),
        .resp          (resp),
        .rdata         (rdata),
        .m_axi_awaddr  (M_AXI_AWADDR),
        .m_axi_awvalid (M_AXI_AWVALID),
        .m_axi_awready (M_AXI_AWREADY),
        .m_axi_awprot  (M_AXI_AWPROT),
        .m_axi_wdata   (M_AXI_WDATA),
        .m_axi_wstrb   (M_AXI_WSTRB),
        .m_axi_wvalid  (M_AXI_WVALID),
        .m_axi_wready  (M_AXI_WREADY),
        .m_axi_bresp   (M_AXI_BRESP),
        .m_axi_bvalid  (M_AXI_BVALID),
        .m_axi_bready  (M_AXI_BREADY),
        .m_axi_araddr  (M_AXI_ARADDR),
        .m_axi_arvalid (M_AXI_ARVALID),
        .m_axi_arready (M_AXI_ARREADY),
        .m_axi_arprot  (M_AXI_ARPROT),
        .m_axi_rdata   (M_AXI_RDATA),
        .m_axi_rresp   (M_AXI_RRESP),
        .m_axi_rvalid  (M_AXI_RVALID),
        .m_axi_rready  (M_AXI_RREADY)
    );

endmodule
